// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader.
// The LOADER_CHECKSUM_EN macro adds the trailing checksum state (ST_CHK).
package loader_pkg;

  localparam int IMEM_AW_DEF = 4;
  localparam int IW_DEF      = 18;

  // Only word[17:16] travel in the B0 byte; the remaining bits must be zero.
  localparam logic [7:0] B0_RSVD_MASK = 8'hFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WR,
`ifdef LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    LANE_HI,
    LANE_MID,
    LANE_LO
  } lane_e;

endpackage

// File: rtl/word_assembler.sv
// Byte-lane capture into an IW-bit instruction word. word_o already includes
// the byte on byte_i in the selected lane, so the final byte can be written straight away.
module word_assembler
  import loader_pkg::*;
#(
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          cap_i,
  input  lane_e         lane_i,
  input  logic [7:0]    byte_i,
  output logic [IW-1:0] word_o
);

  logic [IW-1:0] word_q;
  logic [IW-1:0] word_d;
  logic [IW-1:0] merged;

  always_comb begin
    // NOTE: every path starts from a full default so no latch is inferred.
    merged = word_q;
    unique case (lane_i)
      LANE_HI:  merged[IW-1:16] = byte_i[IW-17:0];
      LANE_MID: merged[15:8]    = byte_i;
      default:  merged[7:0]     = byte_i;
    endcase
  end

  always_comb begin
    word_d = word_q;
    if (clr_i)      word_d = '0;
    else if (cap_i) word_d = merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so all flops update together.
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign word_o = merged;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: header, 3 bytes per word, one imem write each.
// With LOADER_CHECKSUM_EN a trailing XOR checksum byte is verified before done.
module prog_loader
  import loader_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DEF,
  parameter int IW      = IW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [IW-1:0]      imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  localparam logic [IMEM_AW-1:0] CNT_ONE = 1;

  state_e             state_q;
  logic [IMEM_AW-1:0] cnt_q;
  logic [IMEM_AW-1:0] count_q;
  logic               byte_ready_q;
  logic               imem_we_q;
  logic [IMEM_AW-1:0] imem_addr_q;
  logic [IW-1:0]      imem_wdata_q;
  logic               cpu_hold_q;
  logic               done_q;
  logic               err_q;

  logic               xfer;
  logic               load_go;
  logic               hdr_bad;
  logic               b0_bad;
  logic               last_word;
  logic               cap;
  lane_e              lane;
  logic [IW-1:0]      word;

  assign xfer    = byte_valid & byte_ready_q;
  assign load_go = start & ((state_q == ST_IDLE) | (state_q == ST_ERR));
  assign hdr_bad = (byte_data >> IMEM_AW) != 8'd0;
  assign b0_bad  = (byte_data & B0_RSVD_MASK) != 8'd0;
  // A count of 0 encodes the full depth, which the wrapped increment matches naturally.
  assign last_word = (cnt_q + CNT_ONE) == count_q;

  always_comb begin
    lane = LANE_LO;
    cap  = 1'b0;
    unique case (state_q)
      ST_B0:   begin lane = LANE_HI;  cap = xfer; end
      ST_B1:   begin lane = LANE_MID; cap = xfer; end
      ST_B2:   begin lane = LANE_LO;  cap = xfer; end
      default: begin lane = LANE_LO;  cap = 1'b0; end
    endcase
  end

  word_assembler #(.IW(IW)) u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (load_go),
    .cap_i  (cap),
    .lane_i (lane),
    .byte_i (byte_data),
    .word_o (word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       csum_q <= '0;
    else if (load_go) csum_q <= '0;
    else if (cap)     csum_q <= csum_q ^ byte_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      count_q      <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_ERR: begin
          if (load_go) begin
            state_q      <= ST_HDR;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            byte_ready_q <= 1'b1;
            cpu_hold_q   <= 1'b1;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            if (hdr_bad) begin
              state_q      <= ST_ERR;
              err_q        <= 1'b1;
              byte_ready_q <= 1'b0;
            end else begin
              count_q <= byte_data[IMEM_AW-1:0];
              state_q <= ST_B0;
            end
          end
        end
        ST_B0: begin
          if (xfer) begin
            if (b0_bad) begin
              state_q      <= ST_ERR;
              err_q        <= 1'b1;
              byte_ready_q <= 1'b0;
            end else begin
              state_q <= ST_B1;
            end
          end
        end
        ST_B1: begin
          if (xfer) state_q <= ST_B2;
        end
        ST_B2: begin
          if (xfer) begin
            state_q      <= ST_WR;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b1;
            imem_addr_q  <= cnt_q;
            imem_wdata_q <= word;
          end
        end
        ST_WR: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_q      <= ST_CHK;
            byte_ready_q <= 1'b1;
`else
            state_q      <= ST_IDLE;
            done_q       <= 1'b1;
            cpu_hold_q   <= 1'b0;
`endif
          end else begin
            state_q      <= ST_B0;
            byte_ready_q <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer) begin
            byte_ready_q <= 1'b0;
            if (byte_data == csum_q) begin
              state_q    <= ST_IDLE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized byte streams with gaps, checked
// against a stream-level model of expected writes and load outcome.
module tb_prog_loader;

  typedef logic [7:0] u8_t;
  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [17:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t exp_q[$];
  int  done_seen = 0;
  int  wr_seen   = 0;
  int  last_addr = -1;

  prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %s, expected none", name, what);
  endtask

  // Model: walk the stream by the format rules, queue the writes it implies,
  // and report how many bytes the loader will consume and whether it ends in error.
  task automatic model_load(input u8_t s[$], output int n_used, output bit exp_err);
    int  words;
    int  b0, b1, b2;
    u8_t cs;
    n_used  = 1;
    exp_err = 1'b0;
    cs      = 8'h00;
    if (s[0] >= 16) begin
      exp_err = 1'b1;
      return;
    end
    words = (s[0] == 0) ? 16 : int'(s[0]);
    for (int w = 0; w < words; w++) begin
      b0 = s[1 + 3*w];
      n_used++;
      if (b0 > 3) begin
        exp_err = 1'b1;
        return;
      end
      b1 = s[2 + 3*w];
      b2 = s[3 + 3*w];
      n_used += 2;
      exp_q.push_back('{addr: w, data: b0*65536 + b1*256 + b2});
      cs = cs ^ u8_t'(b0) ^ u8_t'(b1) ^ u8_t'(b2);
    end
`ifdef LOADER_CHECKSUM_EN
    n_used++;
    if (s[1 + 3*words] != cs) exp_err = 1'b1;
`endif
  endtask

  task automatic send_byte(input u8_t b, input int gap, input bit with_start, input bit expect_we);
    int n;
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    start      = with_start;
    n = 0;
    while (byte_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      fail_now("ready_timeout", "byte_ready never rose");
      byte_valid = 1'b0;
      start      = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("we_after_byte", {31'd0, imem_we}, {31'd0, expect_we});
  endtask

  task automatic run_load(input u8_t s[$], input int max_gap, input int spur_idx);
    int n_used;
    int n_exp;
    bit exp_err;
    model_load(s, n_used, exp_err);
    n_exp     = exp_q.size();
    done_seen = 0;
    wr_seen   = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hdr_ready", {31'd0, byte_ready}, 32'd1);
    check("start_clears_err", {31'd0, err}, 32'd0);
    check("hold_on_load", {31'd0, cpu_hold}, 32'd1);
    for (int i = 0; i < n_used; i++)
      send_byte(s[i], $urandom_range(0, max_gap), i == spur_idx, (i > 0) && (i % 3 == 0));
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("writes_pending", exp_q.size(), 32'd0);
    check("write_count", wr_seen, n_exp);
    check("done_count", done_seen, exp_err ? 32'd0 : 32'd1);
    check("err_end", {31'd0, err}, {31'd0, exp_err});
    check("hold_end", {31'd0, cpu_hold}, {31'd0, exp_err});
    check("ready_end", {31'd0, byte_ready}, 32'd0);
    exp_q.delete();
  endtask

  // Compare process: every write and done pulse is checked against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_we) begin
        wr_seen++;
        last_addr = imem_addr;
        if (exp_q.size() == 0) begin
          fail_now("write_unexpected", $sformatf("write 0x%0h@%0d", imem_wdata, imem_addr));
        end else begin
          check("wr_addr", imem_addr, exp_q[0].addr);
          check("wr_data", imem_wdata, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        check("wr_ready_low", {31'd0, byte_ready}, 32'd0);
        check("wr_hold", {31'd0, cpu_hold}, 32'd1);
      end
      if (done) begin
        done_seen++;
        check("done_hold_low", {31'd0, cpu_hold}, 32'd0);
      end
    end
  end

  u8_t s_basic[$];
  u8_t s[$];
  int  n_used;
  bit  exp_err;
  u8_t hdr;
  u8_t b0;
  u8_t cs;
  int  words;

  initial begin
    s_basic = {8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
    s_basic.push_back(8'h01);
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_outs", {5'd0, byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err}, 32'd0);
    rst_n = 1'b1;

    // Pin the model against hand-computed words.
    model_load(s_basic, n_used, exp_err);
    check("model_n", exp_q.size(), 32'd2);
    check("model_w0", exp_q[0].data, 32'h12345);
    check("model_a1", exp_q[1].addr, 32'd1);
    check("model_w1", exp_q[1].data, 32'h0ABCD);
    check("model_err", {31'd0, exp_err}, 32'd0);
    exp_q.delete();

    // Basic two-word load, back-to-back bytes.
    run_load(s_basic, 0, -1);

    // Random gaps up to 3 cycles and an ignored mid-load start.
    run_load(s_basic, 3, 2);

    // Header 0: full 16-word load, no seventeenth write.
    s = {8'h00};
    cs = 8'h00;
    for (int w = 0; w < 16; w++) begin
      s.push_back(u8_t'($urandom_range(0, 3)));
      s.push_back(u8_t'($urandom_range(0, 255)));
      s.push_back(u8_t'($urandom_range(0, 255)));
      cs = cs ^ s[3*w+1] ^ s[3*w+2] ^ s[3*w+3];
    end
`ifdef LOADER_CHECKSUM_EN
    s.push_back(cs);
`endif
    run_load(s, 1, -1);
    check("full_writes", wr_seen, 32'd16);
    check("full_last_addr", last_addr, 32'd15);

    // Reserved B0 bit -> error; next start clears it.
    s = {8'h01, 8'h04, 8'h00, 8'h00};
    run_load(s, 1, -1);
    check("b0err_writes", wr_seen, 32'd0);
    run_load(s_basic, 2, -1);

    // Oversized header -> error.
    s = {8'h20};
    run_load(s, 0, -1);

    // Reset between B1 and B2 of word 1.
    model_load(s_basic, n_used, exp_err);
    done_seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(s_basic[i], $urandom_range(0, 2), 1'b0, i == 3);
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {5'd0, byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err}, 32'd0);
    check("midrst_pending", exp_q.size(), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("midrst_no_done", done_seen, 32'd0);
    run_load(s_basic, 1, -1);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum byte.
    s = s_basic;
    s[s.size()-1] = 8'h1C;
    run_load(s, 1, -1);
`endif

    // Randomized loads with occasional malformed headers and B0 bytes.
    for (int k = 0; k < 10; k++) begin
      hdr = u8_t'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) hdr = hdr | (8'h10 << $urandom_range(0, 3));
      words = (hdr[3:0] == 4'd0) ? 16 : int'(hdr[3:0]);
      s  = {hdr};
      cs = 8'h00;
      for (int w = 0; w < words; w++) begin
        b0 = u8_t'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) b0 = b0 | (8'h04 << $urandom_range(0, 5));
        s.push_back(b0);
        s.push_back(u8_t'($urandom_range(0, 255)));
        s.push_back(u8_t'($urandom_range(0, 255)));
        cs = cs ^ s[3*w+1] ^ s[3*w+2] ^ s[3*w+3];
      end
`ifdef LOADER_CHECKSUM_EN
      s.push_back(($urandom_range(0, 3) == 0) ? (cs ^ 8'h01) : cs);
`endif
      run_load(s, 2, $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
